// File: rtl/sat_pkg.sv
// sat_pkg: parameters and types shared by the clause dispatcher and the clause arbiter.
package sat_pkg;
  localparam int OUTPUT_CNT = 4;
  localparam int CLAUSE_WIDTH = 2;
  localparam int ELEMENT_CNT = 4;
  localparam int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1;
  localparam int CLAUSE_BITS = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
  typedef logic [CLAUSE_BITS-1:0] clause_t;
  typedef logic [$clog2(OUTPUT_CNT):0] acc_cnt_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dispatch_state_t;
  localparam acc_cnt_t OCC_MAX = acc_cnt_t'(OUTPUT_CNT);
endpackage

// File: rtl/clause_window.sv
// clause_window: shift window of pending clauses, oldest in slot 0, with same-cycle retire and refill.
module clause_window
  import sat_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  acc_cnt_t                         acc_i,
  input  logic                             wr_en_i,
  input  clause_t                          wr_data_i,
  output acc_cnt_t                         occ_o,
  output logic [OUTPUT_CNT*CLAUSE_BITS-1:0] window_o,
  output logic [OUTPUT_CNT-1:0]            valid_o
);
  clause_t slot_q [OUTPUT_CNT];
  clause_t slot_d [OUTPUT_CNT];
  acc_cnt_t occ_q, occ_d, keep;
  // Survivors shift down by acc; the refill lands just above them.
  always_comb begin
    keep = occ_q - acc_i;
    occ_d = keep + acc_cnt_t'(wr_en_i);
    for (int i = 0; i < OUTPUT_CNT; i++) begin
      slot_d[i] = (wr_en_i && acc_cnt_t'(i) == keep) ? wr_data_i : '0;
      for (int j = 0; j < OUTPUT_CNT; j++)
        if (acc_cnt_t'(i) < keep && acc_cnt_t'(j) == acc_cnt_t'(i) + acc_i) slot_d[i] = slot_q[j];
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      occ_q <= '0;
      for (int i = 0; i < OUTPUT_CNT; i++) slot_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      slot_q <= slot_d;
    end
  for (genvar g = 0; g < OUTPUT_CNT; g++) begin : g_slot
    assign window_o[g*CLAUSE_BITS +: CLAUSE_BITS] = slot_q[g];
    assign valid_o[g] = acc_cnt_t'(g) < occ_q;
  end
  assign occ_o = occ_q;
endmodule

// File: rtl/clause_dispatch_ctrl.sv
// clause_dispatch_ctrl: streams a clause list from memory into the arbiter window, one read per cycle.
module clause_dispatch_ctrl
  import sat_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                clause_count,
  output logic                             mem_rd_en,
  output logic [ADDR_W-1:0]                mem_rd_addr,
  input  clause_t                          mem_rd_data,
  output logic [OUTPUT_CNT*CLAUSE_BITS-1:0] arb_clause,
  output logic [OUTPUT_CNT-1:0]            arb_valid,
  input  acc_cnt_t                         arb_accept_cnt,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  dispatch_state_t state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, sent_q, sent_d, count_q, count_d;
  logic inflight_q, err_q, err_d, start_ok, over;
  acc_cnt_t occ, acc;
  assign start_ok = state_q == IDLE && start;
  assign over = arb_accept_cnt > occ;
  assign acc = over ? occ : arb_accept_cnt;
  always_ff @(posedge clock)
    state_q <= !reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (start ? (clause_count == '0 ? DONE : RUN) : IDLE)
            : state_q == RUN ? (sent_q + ADDR_W'(acc) == count_q ? DONE : RUN)
            : IDLE;
  end
  // Fetch ignores this cycle's accept so occ+inflight can never overrun the window.
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
    mem_rd_en = busy && rd_ptr_q < count_q && occ + acc_cnt_t'(inflight_q) < OCC_MAX;
  end
  always_comb begin
    rd_ptr_d = start_ok ? '0 : rd_ptr_q + ADDR_W'(mem_rd_en);
    sent_d = start_ok ? '0 : sent_q + ADDR_W'(acc);
    count_d = start_ok ? clause_count : count_q;
    err_d = !start_ok && (err_q || over);
  end
  always_ff @(posedge clock)
    if (!reset) begin
      rd_ptr_q <= '0;
      sent_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      sent_q <= sent_d;
      count_q <= count_d;
      inflight_q <= mem_rd_en;
      err_q <= err_d;
    end
  assign mem_rd_addr = rd_ptr_q;
  assign err = err_q;
  clause_window u_window (
    .clk_i    (clock),
    .rst_ni   (reset),
    .acc_i    (acc),
    .wr_en_i  (inflight_q),
    .wr_data_i(mem_rd_data),
    .occ_o    (occ),
    .window_o (arb_clause),
    .valid_o  (arb_valid)
  );
endmodule

// File: doc/clause_dispatch_ctrl.md
Name: clause_dispatch_ctrl

Overview:
- Sequences the clause arbiter (OUTPUT_CNT queue ports, per-queue full flags, accept count) by streaming a clause list from clause memory.
- Holds a shift window of up to OUTPUT_CNT pending clauses, oldest in slot 0, and presents the window to the arbiter.
- Retires the arbiter's per-cycle accept count and refills the window with one memory read per cycle until clause_count clauses are sent.

Parameters:
- OUTPUT_CNT, 4: window slots; must equal the arbiter queue count.
- CLAUSE_WIDTH, 2: literals per clause.
- ELEMENT_CNT, 4: supported variables.
- ELEMENT_BIT_CNT, $clog2(ELEMENT_CNT)+1: bits per literal (derived).
- CLAUSE_BITS, CLAUSE_WIDTH*ELEMENT_BIT_CNT: bits per clause (derived).
- ADDR_W, 8: clause-memory address and clause-count width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; sampled only in IDLE.
- clause_count  in  ADDR_W  number of clauses; captured when start is sampled.
- mem_rd_en  out  1  clause-memory read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  CLAUSE_BITS  read data; valid exactly 1 cycle after mem_rd_en.
- arb_clause  out  OUTPUT_CNT*CLAUSE_BITS  window contents; slot i at bits [i*CLAUSE_BITS +: CLAUSE_BITS].
- arb_valid  out  OUTPUT_CNT  thermometer mask of occupied slots.
- arb_accept_cnt  in  $clog2(OUTPUT_CNT)+1  number of clauses taken this cycle, always the lowest slots.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the last clause is accepted.
- err  out  1  sticky protocol error.

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN: start=1 and clause_count!=0.
  - IDLE to DONE: start=1 and clause_count==0.
  - RUN to DONE: on the edge where sent_cnt+acc == clause_count.
  - DONE to IDLE: unconditionally, after 1 cycle.
  - start is ignored outside IDLE.
- Reset (reset=0 at an edge, including mid-RUN) forces the following, and discards any in-flight read:
  - state=IDLE
  - rd_ptr=0, sent_cnt=0, occ=0, inflight=0
  - all window slots=0
  - arb_valid=0, mem_rd_en=0, busy=0, done=0, err=0
- Fetch:
  - mem_rd_en is combinational, asserted in RUN when rd_ptr<clause_count and occ+inflight<OUTPUT_CNT.
  - The fetch condition is conservative: it ignores the current cycle's accept.
  - mem_rd_addr=rd_ptr; rd_ptr increments on issue.
  - inflight is a 1-bit register equal to the previous cycle's mem_rd_en, so at most one read is outstanding.
- Accept: acc = min(arb_accept_cnt, occ). If arb_accept_cnt>occ, set err; it stays set until the next accepted start or reset.
- Window update at each edge:
  - next slot[i] = slot[i+acc] for i < occ-acc.
  - If inflight, mem_rd_data is written to slot[occ-acc] and occ_next = occ-acc+1; otherwise occ_next = occ-acc.
  - Vacated slots are cleared to 0.
  - A simultaneous accept and refill is legal and loses no data.
- sent_cnt += acc.
- Latency: start sampled at edge E0, then first mem_rd_en in cycle E0..E1, then data captured at E2, then arb_valid=0001 after E2.
- Sustained rate: one clause per cycle when the arbiter accepts every cycle.
- Widths: occ, acc and arb_accept_cnt are $clog2(OUTPUT_CNT)+1 bits. rd_ptr and sent_cnt are ADDR_W bits and never exceed clause_count (no wrap).
- clause_count=2^ADDR_W-1 is legal.
- done stays 0 in RUN. busy=1 only in RUN.

Decomposition:
- Shared package sat_pkg holds:
  - OUTPUT_CNT, CLAUSE_WIDTH, ELEMENT_CNT, ELEMENT_BIT_CNT, CLAUSE_BITS (shared with the clause arbiter).
  - typedef clause_t = logic [CLAUSE_BITS-1:0].
  - typedef acc_cnt_t = logic [$clog2(OUTPUT_CNT):0].
  - dispatch state enum {IDLE, RUN, DONE}.
- One natural sub-module, clause_window: shift/refill window holding occ, slots and the valid mask. Inputs: acc, wr_en, wr_data. Outputs: occ, window, valid.

Test Plan:
- Reset mid-RUN: clause_count=8, drive reset=0 after 3 clauses are accepted.
  - Next cycle: arb_valid=0, busy=0, mem_rd_en=0.
  - A new start with count=2 fetches from addr 0.
- Full throughput: clause_count=3, memory data = addr+1, arb_accept_cnt = popcount(arb_valid) every cycle.
  - mem_rd_addr sequence 0,1,2.
  - Each clause is seen in slot 0 exactly once.
  - done pulses once, 1 cycle after the third accept.
- Backpressure: clause_count=6, arb_accept_cnt=0 for 8 cycles, then 2 per cycle.
  - mem_rd_en issues exactly 4 reads, then stalls with arb_valid=1111.
  - Once accepts resume, the slots shift in order, refills continue, and all 6 clauses are accepted in order.
- Simultaneous accept and refill: occ=2, accept 1 while a read returns.
  - Next cycle: arb_valid=0011, old slot1 now in slot0, new data in slot1.
- Zero count and ignored start:
  - start with clause_count=0 gives done=1 after 1 cycle with no mem_rd_en.
  - start pulsed during RUN has no effect on rd_ptr or clause_count.
- Over-accept error: occ=1 and arb_accept_cnt=3.
  - acc is clamped to 1 and err=1, held until the next start.
